// File: rtl/icache_line_fill.sv
// Direct-mapped 4 KB instruction cache (64 lines x 16 words) with a single
// outstanding line refill. Define ICACHE_PERF_CNT_EN to add hit/miss counters.
module icache_line_fill (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_o,
    input  logic        flush_i,
    output logic        miss_o,
    output logic [31:0] miss_addr_o,
    input  logic        refill_we_i,
    input  logic [31:0] refill_addr_i,
    input  logic [31:0] refill_data_i,
    input  logic        refill_idle_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [63:0] r_valid;
    logic [19:0] r_tag  [0:63];
    logic [31:0] r_data [0:1023];
    logic        r_miss;
    logic [31:0] r_missAddr;
    logic        r_flushPend;

    logic [3:0]  w_offset;
    logic [5:0]  w_index;
    logic [19:0] w_tag;
    logic [5:0]  w_fillIndex;
    logic        w_hit;
    logic        w_startMiss;
    logic        w_unused;

    assign w_offset    = if_addr_i[5:2];
    assign w_index     = if_addr_i[11:6];
    assign w_tag       = if_addr_i[31:12];
    assign w_fillIndex = r_missAddr[11:6];
    assign w_unused    = ^{if_addr_i[1:0], refill_addr_i[31:12], refill_addr_i[1:0]};

    // A hit is suppressed while in reset or while a flush is being applied.
    assign w_hit = if_req_i & ~rst & ~flush_i & (r_state == IDLE)
                 & r_valid[w_index] & (r_tag[w_index] == w_tag);

    assign w_startMiss  = (r_state == IDLE) & if_req_i & ~w_hit;

    assign inst_o       = r_data[{w_index, w_offset}];
    assign inst_valid_o = w_hit;
    assign stall_o      = if_req_i & ~w_hit;
    assign miss_o       = r_miss;
    assign miss_addr_o  = r_missAddr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_startMiss)    w_nextState = REQ;
            REQ:     if (!refill_idle_i) w_nextState = FILL;
            FILL:    if (refill_idle_i)  w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Flushes arriving mid-refill are held until the burst has drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_miss      <= 1'b0;
            r_missAddr  <= 32'h0;
            r_valid     <= '0;
            r_flushPend <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_i) r_valid <= '0;
                    if (w_startMiss) begin
                        r_missAddr       <= {if_addr_i[31:6], 6'b0};
                        r_miss           <= 1'b1;
                        r_valid[w_index] <= 1'b0;
                    end
                end
                REQ: begin
                    if (flush_i)        r_flushPend <= 1'b1;
                    if (!refill_idle_i) r_miss      <= 1'b0;
                end
                FILL: begin
                    if (refill_idle_i) begin
                        if (r_flushPend || flush_i) r_valid <= '0;
                        else                        r_valid[w_fillIndex] <= 1'b1;
                        r_flushPend <= 1'b0;
                    end else if (flush_i) begin
                        r_flushPend <= 1'b1;
                    end
                end
                default: r_miss <= 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_startMiss) r_tag[w_index] <= w_tag;
    end

    always_ff @(posedge clk) begin
        if (refill_we_i) r_data[refill_addr_i[11:2]] <= refill_data_i;
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hitCnt;
    logic [31:0] r_missCnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hitCnt  <= 32'h0;
            r_missCnt <= 32'h0;
        end else begin
            if (w_hit)       r_hitCnt  <= r_hitCnt + 32'd1;
            if (w_startMiss) r_missCnt <= r_missCnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hitCnt;
    assign miss_cnt_o = r_missCnt;
`endif

endmodule

// File: tb/tb_icache_line_fill.sv
// Directed self-checking bench for icache_line_fill: miss/refill/hit, line
// conflicts, flush in IDLE and mid-burst, and reset during a refill.
module tb_icache_line_fill;

    logic        clk;
    logic        rst;
    logic        ifReq;
    logic [31:0] ifAddr;
    logic [31:0] inst;
    logic        instValid;
    logic        stall;
    logic        flush;
    logic        miss;
    logic [31:0] missAddr;
    logic        refillWe;
    logic [31:0] refillAddr;
    logic [31:0] refillData;
    logic        refillIdle;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hitCnt;
    logic [31:0] missCnt;
`endif

    int total = 0;
    int bad   = 0;

    icache_line_fill dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (ifReq),
        .if_addr_i     (ifAddr),
        .inst_o        (inst),
        .inst_valid_o  (instValid),
        .stall_o       (stall),
        .flush_i       (flush),
        .miss_o        (miss),
        .miss_addr_o   (missAddr),
        .refill_we_i   (refillWe),
        .refill_addr_i (refillAddr),
        .refill_data_i (refillData),
        .refill_idle_i (refillIdle)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_cnt_o     (hitCnt),
        .miss_cnt_o    (missCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bridge model: 16 beats from base, optional flush pulse or reset at a beat.
    task automatic applyStimulus(input logic [31:0] base, input logic [31:0] val0,
                                 input int flushAt, input int rstAt);
        bit aborted;
        aborted = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == rstAt) begin
                rst      = 1'b1;
                refillWe = 1'b0;
                flush    = 1'b0;
                tick();
                rst        = 1'b0;
                refillIdle = 1'b1;
                aborted    = 1'b1;
                break;
            end
            flush      = (k == flushAt);
            refillWe   = 1'b1;
            refillAddr = base + 32'(4 * k);
            refillData = val0 + 32'(k);
            refillIdle = 1'b0;
            tick();
        end
        if (!aborted) begin
            refillWe   = 1'b0;
            flush      = 1'b0;
            refillIdle = 1'b1;
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        ifReq      = 1'b0;
        ifAddr     = 32'h0;
        flush      = 1'b0;
        refillWe   = 1'b0;
        refillAddr = 32'h0;
        refillData = 32'h0;
        refillIdle = 1'b1;
        tick();
        tick();
        checkOutput("rst_miss", {31'b0, miss}, 32'h0);
        checkOutput("rst_missAddr", missAddr, 32'h0);
        checkOutput("rst_stall_noreq", {31'b0, stall}, 32'h0);
        ifReq  = 1'b1;
        ifAddr = 32'hBFC00034;
        #1;
        checkOutput("rst_stall_req", {31'b0, stall}, 32'h1);
        checkOutput("rst_instValid", {31'b0, instValid}, 32'h0);

        rst = 1'b0;
        #1;
        checkOutput("cold_stall", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("cold_miss", {31'b0, miss}, 32'h1);
        checkOutput("cold_missAddr", missAddr, 32'hBFC00000);
        checkOutput("cold_stallReq", {31'b0, stall}, 32'h1);
        ifAddr = 32'h12345678;
        tick();
        checkOutput("req_holdMiss", {31'b0, miss}, 32'h1);
        checkOutput("req_holdAddr", missAddr, 32'hBFC00000);
        ifAddr = 32'hBFC00034;
        applyStimulus(32'hBFC00000, 32'hA0, -1, -1);
        checkOutput("fill_missDone", {31'b0, miss}, 32'h0);
        checkOutput("hit34_valid", {31'b0, instValid}, 32'h1);
        checkOutput("hit34_inst", inst, 32'hAD);
        checkOutput("hit34_stall", {31'b0, stall}, 32'h0);
        tick();
        ifAddr = 32'hBFC00008;
        #1;
        checkOutput("hit08_valid", {31'b0, instValid}, 32'h1);
        checkOutput("hit08_inst", inst, 32'hA2);
        tick();
        ifReq = 1'b0;
`ifdef ICACHE_PERF_CNT_EN
        checkOutput("perf_miss", missCnt, 32'd1);
        checkOutput("perf_hit", hitCnt, 32'd2);
`endif

        ifReq  = 1'b1;
        ifAddr = 32'h00001000;
        #1;
        checkOutput("c1_stall", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("c1_missAddr", missAddr, 32'h00001000);
        applyStimulus(32'h00001000, 32'h100, -1, -1);
        ifAddr = 32'h00001004;
        #1;
        checkOutput("c1_hitInst", inst, 32'h101);
        ifAddr = 32'h00002000;
        #1;
        checkOutput("c2_stall", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("c2_missAddr", missAddr, 32'h00002000);
        applyStimulus(32'h00002000, 32'h200, -1, -1);
        ifAddr = 32'h00002010;
        #1;
        checkOutput("c2_hitInst", inst, 32'h204);
        ifAddr = 32'h00001000;
        #1;
        checkOutput("c3_stall", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("c3_miss", {31'b0, miss}, 32'h1);
        checkOutput("c3_missAddr", missAddr, 32'h00001000);
        applyStimulus(32'h00001000, 32'h100, -1, -1);

        ifAddr = 32'h00000440;
        tick();
        checkOutput("f_missAddr", missAddr, 32'h00000440);
        applyStimulus(32'h00000440, 32'h300, 5, -1);
        checkOutput("f_noHit", {31'b0, instValid}, 32'h0);
        checkOutput("f_stall", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("f_remiss", {31'b0, miss}, 32'h1);
        applyStimulus(32'h00000440, 32'h300, -1, -1);
        ifAddr = 32'h00000448;
        #1;
        checkOutput("f_hitInst", inst, 32'h302);
        checkOutput("f_hitValid", {31'b0, instValid}, 32'h1);

        flush = 1'b1;
        #1;
        checkOutput("fi_suppress", {31'b0, instValid}, 32'h0);
        ifReq = 1'b0;
        tick();
        flush = 1'b0;
        ifReq = 1'b1;
        #1;
        checkOutput("fi_invalid", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("fi_miss", {31'b0, miss}, 32'h1);

        applyStimulus(32'h00000440, 32'h300, -1, 7);
        checkOutput("r_miss", {31'b0, miss}, 32'h0);
        checkOutput("r_missAddr", missAddr, 32'h0);
        checkOutput("r_stall", {31'b0, stall}, 32'h1);
        tick();
        checkOutput("r_remiss", {31'b0, miss}, 32'h1);
        checkOutput("r_remissAddr", missAddr, 32'h00000440);
        applyStimulus(32'h00000440, 32'h300, -1, -1);
        checkOutput("r_hitInst", inst, 32'h302);
        checkOutput("r_hitValid", {31'b0, instValid}, 32'h1);

        ifReq = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_line_fill.md
ICACHE_LINE_FILL -- requirements
Module: icache_line_fill

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 if_req_i  in  1  fetch request from IF stage.
REQ-004 if_addr_i  in  32  fetch PC; bits [1:0] ignored.
REQ-005 inst_o  out  32  fetched instruction; meaningful only when inst_valid_o=1.
REQ-006 inst_valid_o  out  1  hit this cycle.
REQ-007 stall_o  out  1  IF must hold if_addr_i.
REQ-008 flush_i  in  1  invalidate all lines.
REQ-009 miss_o  out  1  miss request to AXI bus bridge (its icache-miss input).
REQ-010 miss_addr_o  out  32  line-aligned refill base; feeds bridge fetch-PC input.
REQ-011 refill_we_i  in  1  refill beat strobe from bridge.
REQ-012 refill_addr_i  in  32  refill beat word address.
REQ-013 refill_data_i  in  32  refill beat data.
REQ-014 refill_idle_i  in  1  bridge icache-idle flag; 1=idle, 0=burst in flight.

Function
REQ-015 Geometry: direct-mapped, 64 lines x 16 words (4 KB); offset=addr[5:2], index=addr[11:6], tag=addr[31:12].
REQ-016 Hit = if_req_i & state IDLE & valid[index] & tag match; lookup combinational, zero latency.
REQ-017 On hit: inst_valid_o=1, inst_o=data[index][offset], stall_o=0.
REQ-018 stall_o = if_req_i & ~hit; inst_valid_o=0 whenever stall_o=1.
REQ-019 States: IDLE, REQ, FILL.
REQ-020 IDLE -> REQ on if_req_i & ~hit; same edge: miss_addr_o <= {if_addr_i[31:6],6'b0}, miss_o <= 1, valid[index] <= 0, tag[index] <= new tag.
REQ-021 REQ: miss_o held 1, miss_addr_o stable; on refill_idle_i=0 -> FILL, miss_o <= 0.
REQ-022 FILL: each refill_we_i=1 writes refill_data_i to data[refill_addr_i[11:6]][refill_addr_i[5:2]]; miss_addr_o stable throughout (bridge adds its beat offset to it).
REQ-023 FILL -> IDLE on refill_idle_i=1; same edge valid[line] <= 1; lookup replays next cycle and hits.
REQ-024 Beat writes accepted in any state; bridge guarantees 16 beats per burst, last beat coincident with refill_idle_i rising edge's preceding cycle.
REQ-025 flush_i in IDLE: all valid bits cleared next edge; no hit reported that cycle.
REQ-026 flush_i in REQ/FILL: recorded as pending; applied on FILL->IDLE edge, overriding the valid set; outstanding burst always completes.
REQ-027 if_addr_i changes while stalled are ignored until return to IDLE.
REQ-028 miss_addr_o wraps nothing; bits [5:0] always 0.

Reset
REQ-029 rst: state IDLE, miss_o=0, miss_addr_o=0, all valid bits 0, flush pending 0; data/tag arrays not reset.
REQ-030 rst mid-REQ/FILL: aborts immediately; bridge reset concurrently; line left invalid.
REQ-031 Outputs during rst-held cycles: inst_valid_o=0, stall_o=if_req_i.

Configuration
REQ-032 Macro ICACHE_PERF_CNT_EN defined: adds out ports hit_cnt_o[31:0], miss_cnt_o[31:0]; +1 per hit cycle / per IDLE->REQ transition; wrap at 2^32; cleared by rst.
REQ-033 Macro undefined: ports and counters absent; all other behaviour identical.

Verification
REQ-034 After rst, if_req_i=1, addr 0xBFC00034 -> next cycle miss_o=1, miss_addr_o=0xBFC00000, stall_o=1.
REQ-035 Bridge returns 16 beats 0xA0..0xAF at 0xBFC00000+4k, then refill_idle_i=1 -> next cycle inst_valid_o=1, inst_o=0xAD for 0xBFC00034; 0xBFC00008 hits with 0xA2.
REQ-036 Conflict: fill 0x00001000, then fetch 0x00002000 -> miss, miss_addr_o=0x00002000; afterwards 0x00001000 misses again.
REQ-037 flush_i pulse during FILL -> line not valid after burst; same fetch re-misses, miss_o=1.
REQ-038 rst asserted at beat 7 of FILL -> state IDLE, miss_o=0; refetch of same address misses.
REQ-039 ICACHE_PERF_CNT_EN: sequence of REQ-034/035 -> miss_cnt_o=1, hit_cnt_o=2.
